// File: rtl/writeback_unit_pkg.sv
// Shared core definitions for the writeback slice.
//   CORE_XLEN / CORE_BUF_DEPTH : default datapath width and pending-write buffer depth
//   INSTR_*                    : instruction IDs carried on the MEM_WB / late-load paths
//   wb_src_e                   : which source wins the register-file write port this cycle
package writeback_unit_pkg;

  localparam int unsigned CORE_XLEN      = 32;
  localparam int unsigned CORE_BUF_DEPTH = 4;

  localparam logic [5:0] INSTR_ADD = 6'd1;
  localparam logic [5:0] INSTR_LB  = 6'd8;
  localparam logic [5:0] INSTR_LH  = 6'd9;
  localparam logic [5:0] INSTR_LW  = 6'd10;
  localparam logic [5:0] INSTR_LBU = 6'd11;
  localparam logic [5:0] INSTR_LHU = 6'd12;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LATE,
    WB_SRC_BUF,
    WB_SRC_PIPE
  } wb_src_e;

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// load_formatter: extracts and extends load data.
//   instr_id  : instruction ID (INSTR_LB/LH/LW/LBU/LHU select formatting)
//   mem_data  : raw aligned memory word
//   addr_lo   : low address bits selecting byte/halfword
//   alu_value : value used when instr_id is not a load
//   value     : formatted register write value
module load_formatter
  import writeback_unit_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic [5:0]      instr_id,
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] alu_value,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_data[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
    case (instr_id)
      INSTR_LB:  value = XLEN'($signed(byte_sel));
      INSTR_LH:  value = XLEN'($signed(half_sel));
      INSTR_LW:  value = XLEN'($signed(mem_data[31:0]));
      INSTR_LBU: value = XLEN'(byte_sel);
      INSTR_LHU: value = XLEN'(half_sel);
      default:   value = alu_value;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates register-file writes between late (cache-miss) load
// returns, a small in-order pending-write buffer, and the MEM_WB pipeline slot.
//   clk, rst            : clock, asynchronous active-high reset
//   pipe_*_in           : MEM_WB slot payload; pipe_ready_out = buffer has room
//   ld_*_in             : late load return (always accepted, highest priority)
//   ld_issue_*_in       : late load issued, marks rd pending
//   rf_*_out            : registered register-file write port
//   pending_mask_out    : bit n set while a late load to xn is outstanding
//   buf_count_out       : pending-write buffer occupancy
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned XLEN      = CORE_XLEN,
  parameter int unsigned BUF_DEPTH = CORE_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_valid_in,
  input  logic                         pipe_rd_valid_in,
  input  logic [4:0]                   pipe_rd_addr_in,
  input  logic [XLEN-1:0]              pipe_rd_value_in,
  input  logic [XLEN-1:0]              pipe_mem_data_in,
  input  logic [1:0]                   pipe_addr_lo_in,
  input  logic [5:0]                   pipe_instr_id_in,
  output logic                         pipe_ready_out,
  input  logic                         ld_valid_in,
  input  logic [4:0]                   ld_rd_addr_in,
  input  logic [XLEN-1:0]              ld_data_in,
  input  logic [1:0]                   ld_addr_lo_in,
  input  logic [5:0]                   ld_instr_id_in,
  input  logic                         ld_issue_valid_in,
  input  logic [4:0]                   ld_issue_rd_in,
  output logic                         rf_wr_en_out,
  output logic [4:0]                   rf_rd_addr_out,
  output logic [XLEN-1:0]              rf_rd_value_out,
  output logic [31:0]                  pending_mask_out,
  output logic [$clog2(BUF_DEPTH):0]   buf_count_out
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pipe_fmt;
  logic [XLEN-1:0] ld_fmt;

  logic [4:0]      buf_addr  [BUF_DEPTH];
  logic [XLEN-1:0] buf_value [BUF_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            cand;
  logic            accept;
  logic            ld_wr;
  logic            push;
  logic            pop;
  wb_src_e         src;
  logic [4:0]      win_addr;
  logic [XLEN-1:0] win_value;

  logic [31:0]     mask_set;
  logic [31:0]     mask_clr;

  load_formatter #(.XLEN(XLEN)) u_pipe_fmt (
    .instr_id  (pipe_instr_id_in),
    .mem_data  (pipe_mem_data_in),
    .addr_lo   (pipe_addr_lo_in),
    .alu_value (pipe_rd_value_in),
    .value     (pipe_fmt)
  );

  load_formatter #(.XLEN(XLEN)) u_ld_fmt (
    .instr_id  (ld_instr_id_in),
    .mem_data  (ld_data_in),
    .addr_lo   (ld_addr_lo_in),
    .alu_value (ld_data_in),
    .value     (ld_fmt)
  );

  assign pipe_ready_out = (count < CW'(BUF_DEPTH));
  assign buf_count_out  = count;

  assign cand   = pipe_valid_in && pipe_rd_valid_in && (pipe_rd_addr_in != 5'd0);
  assign accept = cand && pipe_ready_out;
  assign ld_wr  = ld_valid_in && (ld_rd_addr_in != 5'd0);

  // Bypass only when nothing older is queued and the late load is not taking
  // the port; otherwise the candidate queues behind the buffer to keep order.
  always_comb begin
    src       = WB_SRC_NONE;
    win_addr  = '0;
    win_value = '0;
    push      = 1'b0;
    pop       = 1'b0;
    if (ld_wr) begin
      src       = WB_SRC_LATE;
      win_addr  = ld_rd_addr_in;
      win_value = ld_fmt;
      push      = accept;
    end else if (count != '0) begin
      src       = WB_SRC_BUF;
      win_addr  = buf_addr[rd_ptr];
      win_value = buf_value[rd_ptr];
      pop       = 1'b1;
      push      = accept;
    end else if (accept) begin
      src       = WB_SRC_PIPE;
      win_addr  = pipe_rd_addr_in;
      win_value = pipe_fmt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr]  <= pipe_rd_addr_in;
      buf_value[wr_ptr] <= pipe_fmt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en_out    <= 1'b0;
      rf_rd_addr_out  <= '0;
      rf_rd_value_out <= '0;
    end else begin
      rf_wr_en_out <= (src != WB_SRC_NONE);
      if (src != WB_SRC_NONE) begin
        rf_rd_addr_out  <= win_addr;
        rf_rd_value_out <= win_value;
      end
    end
  end

  // Set is applied after clear so a same-cycle issue and return leaves the bit set.
  always_comb begin
    mask_set = '0;
    mask_clr = '0;
    if (ld_issue_valid_in && (ld_issue_rd_in != 5'd0)) mask_set[ld_issue_rd_in] = 1'b1;
    if (ld_valid_in) mask_clr[ld_rd_addr_in] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_mask_out <= '0;
    else     pending_mask_out <= (pending_mask_out & ~mask_clr) | mask_set;
  end

endmodule
